// File: rtl/crop_window.sv
// -----------------------------------------------------------------------------
// crop_window
//   Takes a single-pixel raster AXI-Stream and forwards only the
//   OUT_ROWS x OUT_COLS window whose top-left corner is (crop_x0, crop_y0).
//   Every other pixel is accepted and dropped. The output stream is framed:
//   tuser marks the first window pixel of a frame and tlast marks the last
//   pixel of each window line.
//
// Ports
//   clk            single clock
//   s_axis_resetn  synchronous active-low reset
//   s_axis_*       input pixel stream (tuser = start of frame)
//   crop_x0/y0     window origin, latched on the SOF beat and clamped so the
//                  window always fits inside the frame
//   m_axis_*       cropped pixel stream, one output register, 1-cycle latency
//
// Optional feature (macro CROP_WINDOW_STATUS_EN)
//   frame_done     one-cycle pulse on the output beat carrying the last
//                  window pixel of a frame
//   err_sof_early  sticky flag, set when an SOF arrives while a frame is
//                  still being scanned; cleared only by reset
// -----------------------------------------------------------------------------
module crop_window #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS         = 100,
  parameter int IN_COLS         = 160,
  parameter int OUT_ROWS        = 48,
  parameter int OUT_COLS        = 48
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0] crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast
`ifdef CROP_WINDOW_STATUS_EN
  ,
  output logic                       frame_done,
  output logic                       err_sof_early
`endif
);

  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);

  localparam logic [CW-1:0] X0_MAX   = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] Y0_MAX   = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_ROWS - 1);
  // Window extents in one extra bit so origin + size can never wrap.
  localparam logic [CW:0]   OUT_COLS_W = (CW+1)'(OUT_COLS);
  localparam logic [RW:0]   OUT_ROWS_W = (RW+1)'(OUT_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [RW-1:0]              r_row;
  logic [CW-1:0]              r_col;
  logic [RW-1:0]              w_row_nxt;
  logic [CW-1:0]              w_col_nxt;
  logic [CW-1:0]              r_x0;
  logic [RW-1:0]              r_y0;

  logic                       r_m_tvalid;
  logic [PIXEL_BIT_WIDTH-1:0] r_m_tdata;
  logic                       r_m_tuser;
  logic                       r_m_tlast;

  logic                       w_in_beat;
  logic                       w_pix_live;
  logic [RW-1:0]              w_cur_row;
  logic [CW-1:0]              w_cur_col;
  logic [CW-1:0]              w_cur_x0;
  logic [RW-1:0]              w_cur_y0;
  logic [CW-1:0]              w_x0_clamp;
  logic [RW-1:0]              w_y0_clamp;
  logic [RW:0]                w_row_ext;
  logic [CW:0]                w_col_ext;
  logic [RW:0]                w_y0_ext;
  logic [CW:0]                w_x0_ext;
  logic                       w_in_window;
  logic                       w_is_first;
  logic                       w_is_tlast;

  assign w_x0_clamp = (crop_x0 > X0_MAX) ? X0_MAX : crop_x0;
  assign w_y0_clamp = (crop_y0 > Y0_MAX) ? Y0_MAX : crop_y0;
  assign w_in_beat  = s_axis_tvalid & s_axis_tready;

  // Position and window origin that apply to the pixel currently on the input.
  // An SOF pixel is always (0,0) and uses the freshly clamped origin, so the
  // window test is correct on the very beat that latches the origin.
  always_comb begin
    w_cur_row  = r_row;
    w_cur_col  = r_col;
    w_cur_x0   = r_x0;
    w_cur_y0   = r_y0;
    w_pix_live = 1'b0;
    if (s_axis_tuser) begin
      w_cur_row  = {RW{1'b0}};
      w_cur_col  = {CW{1'b0}};
      w_cur_x0   = w_x0_clamp;
      w_cur_y0   = w_y0_clamp;
      w_pix_live = 1'b1;
    end else begin
      case (r_state)
        ST_ACTIVE: w_pix_live = 1'b1;
        default:   w_pix_live = 1'b0;
      endcase
    end
  end

  assign w_row_ext = {1'b0, w_cur_row};
  assign w_col_ext = {1'b0, w_cur_col};
  assign w_y0_ext  = {1'b0, w_cur_y0};
  assign w_x0_ext  = {1'b0, w_cur_x0};

  assign w_in_window = w_pix_live
                     & (w_row_ext >= w_y0_ext) & (w_row_ext < (w_y0_ext + OUT_ROWS_W))
                     & (w_col_ext >= w_x0_ext) & (w_col_ext < (w_x0_ext + OUT_COLS_W));
  assign w_is_first  = (w_cur_row == w_cur_y0) & (w_cur_col == w_cur_x0);
  assign w_is_tlast  = (w_col_ext == (w_x0_ext + OUT_COLS_W - (CW+1)'(1)));

  // Only window pixels can be blocked by a full output register.
  assign s_axis_tready = s_axis_resetn & (~w_in_window | ~r_m_tvalid | m_axis_tready);

  // Raster counter advance and frame state on each accepted live pixel.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    if (w_in_beat && w_pix_live) begin
      if (w_cur_col == LAST_COL) begin
        w_col_nxt = {CW{1'b0}};
        if (w_cur_row == LAST_ROW) begin
          w_row_nxt   = {RW{1'b0}};
          w_state_nxt = ST_DONE;
        end else begin
          w_row_nxt   = w_cur_row + RW'(1);
          w_state_nxt = ST_ACTIVE;
        end
      end else begin
        w_col_nxt   = w_cur_col + CW'(1);
        w_row_nxt   = w_cur_row;
        w_state_nxt = ST_ACTIVE;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, raster counters and per-frame window origin.
  always_ff @(posedge clk) begin
    if (!s_axis_resetn) begin
      r_state <= ST_IDLE;
      r_row   <= {RW{1'b0}};
      r_col   <= {CW{1'b0}};
      r_x0    <= {CW{1'b0}};
      r_y0    <= {RW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      if (w_in_beat && s_axis_tuser) begin
        r_x0 <= w_x0_clamp;
        r_y0 <= w_y0_clamp;
      end
    end
  end

  // Single output register: load a window pixel, otherwise empty on a
  // downstream beat, otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (!s_axis_resetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= {PIXEL_BIT_WIDTH{1'b0}};
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_in_beat && w_in_window) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
      r_m_tuser  <= w_is_first;
      r_m_tlast  <= w_is_tlast;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;

`ifdef CROP_WINDOW_STATUS_EN
  logic w_is_last_px;
  logic r_frame_last;
  logic r_err_sof_early;

  assign w_is_last_px = w_is_tlast
                      & (w_row_ext == (w_y0_ext + OUT_ROWS_W - (RW+1)'(1)));

  // Tags the buffered pixel as the frame's last window pixel; sticky early-SOF flag.
  always_ff @(posedge clk) begin
    if (!s_axis_resetn) begin
      r_frame_last    <= 1'b0;
      r_err_sof_early <= 1'b0;
    end else begin
      if (w_in_beat && w_in_window) begin
        r_frame_last <= w_is_last_px;
      end
      if (w_in_beat && s_axis_tuser && (r_state == ST_ACTIVE)) begin
        r_err_sof_early <= 1'b1;
      end
    end
  end

  assign frame_done    = r_m_tvalid & m_axis_tready & r_frame_last;
  assign err_sof_early = r_err_sof_early;
`endif

endmodule

// File: tb/tb_crop_window.sv
// Directed bench for crop_window with default parameters (160x100 -> 48x48).
// Input pixel data is its raster index (row*160+col), so the k-th window beat
// must carry (y0 + k/48)*160 + x0 + k%48.
module tb_crop_window;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        s_tuser;
  logic [7:0]  crop_x0;
  logic [6:0]  crop_y0;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        m_tuser;
  logic        m_tlast;
`ifdef CROP_WINDOW_STATUS_EN
  logic        frame_done;
  logic        err_sof_early;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  int          k;
  int          exp_x0;
  int          exp_y0;
  bit          chk_lat;
  logic [15:0] last_acc;
  bit          prev_stall;
  logic [15:0] held_d;
  logic        held_u;
  logic        held_l;

  always #5 clk = ~clk;

  crop_window dut (
    .clk           (clk),
    .s_axis_resetn (resetn),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .crop_x0       (crop_x0),
    .crop_y0       (crop_y0),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast)
`ifdef CROP_WINDOW_STATUS_EN
    ,
    .frame_done    (frame_done),
    .err_sof_early (err_sof_early)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at each negedge: output beat checking, stall hold, latency.
  task automatic check_out();
    int  exp_d;
    bit  beat;
    beat = m_tvalid && m_tready;
    if (prev_stall) begin
      check("hold_valid", 32'(m_tvalid), 32'd1);
      check("hold_data", 32'(m_tdata), 32'(held_d));
      check("hold_flags", 32'({m_tuser, m_tlast}), 32'({held_u, held_l}));
    end
    if (chk_lat && m_tvalid) check("latency", 32'(m_tdata), 32'(last_acc));
`ifdef CROP_WINDOW_STATUS_EN
    check("frame_done", 32'(frame_done), 32'(beat && (k == 2303)));
`endif
    if (beat) begin
      exp_d = (exp_y0 + k / 48) * 160 + exp_x0 + (k % 48);
      check("beat_data", 32'(m_tdata), 32'(exp_d));
      check("beat_tuser", 32'(m_tuser), 32'(k == 0));
      check("beat_tlast", 32'(m_tlast), 32'((k % 48) == 47));
      k++;
    end
    prev_stall = m_tvalid && !m_tready;
    held_d = m_tdata;
    held_u = m_tuser;
    held_l = m_tlast;
    if (s_tvalid && s_tready) last_acc = s_tdata;
  endtask

  task automatic begin_frame(input int cx, input int cy, input int ex, input int ey);
    crop_x0 = 8'(cx);
    crop_y0 = 7'(cy);
    exp_x0  = ex;
    exp_y0  = ey;
    k       = 0;
  endtask

  // Offers pixels first..first+count-1 (SOF on the first if sof=1) with
  // random tvalid/tready density in percent. Entered and left at posedge+1.
  task automatic run_pixels(input int first, input int count, input bit sof,
                            input int vprob, input int rprob);
    int p = 0;
    int cyc = 0;
    while (p < count && cyc < count * 20 + 200) begin
      s_tvalid = ($urandom_range(99) < vprob);
      s_tdata  = 16'(first + p);
      s_tuser  = sof && (p == 0);
      m_tready = ($urandom_range(99) < rprob);
      @(negedge clk);
      check_out();
      if (s_tvalid && s_tready) p++;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (p < count) check("run_timeout", 32'(p), 32'(count));
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input int rprob);
    bit empty = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    for (int c = 0; c < 64 && !empty; c++) begin
      m_tready = ($urandom_range(99) < rprob);
      @(negedge clk);
      check_out();
      empty = !m_tvalid;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    int k_before;
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 16'd0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    crop_x0  = 8'd0;
    crop_y0  = 7'd0;
    chk_lat  = 1'b0;
    prev_stall = 1'b0;
    last_acc = 16'd0;
    k = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_flags", 32'({m_tuser, m_tlast}), 32'd0);
`ifdef CROP_WINDOW_STATUS_EN
    check("rst_err", 32'(err_sof_early), 32'd0);
`endif
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // T1: crop (0,0), full rate, 1-cycle latency and no bubbles
    begin_frame(0, 0, 0, 0);
    chk_lat = 1'b1;
    run_pixels(0, 16000, 1'b1, 100, 100);
    drain(100);
    chk_lat = 1'b0;
    check("t1_beats", 32'(k), 32'd2304);

    // After a complete frame, pixels without SOF are dropped
    k_before = k;
    run_pixels(0, 50, 1'b0, 100, 100);
    drain(100);
    check("done_drop", 32'(k), 32'(k_before));

    // T2: crop (112,52): first 8432, last 15999
    begin_frame(112, 52, 112, 52);
    run_pixels(0, 16000, 1'b1, 100, 100);
    drain(100);
    check("t2_beats", 32'(k), 32'd2304);
`ifdef CROP_WINDOW_STATUS_EN
    check("t2_err", 32'(err_sof_early), 32'd0);
`endif

    // T5: early SOF after 5000 pixels of a (0,0) frame; 31 rows*48 + 40 beats
    begin_frame(0, 0, 0, 0);
    run_pixels(0, 5000, 1'b1, 100, 100);
    drain(100);
    check("t5_trunc_beats", 32'(k), 32'd1528);

    // T4 (restart frame of T5): random tvalid and 50% tready backpressure
    begin_frame(0, 0, 0, 0);
    run_pixels(0, 16000, 1'b1, 85, 50);
    drain(50);
    check("t4_beats", 32'(k), 32'd2304);
`ifdef CROP_WINDOW_STATUS_EN
    check("t5_err", 32'(err_sof_early), 32'd1);
`endif

    // T6: reset for one cycle while pixel 1619 (row 10, col 19) is buffered
    begin_frame(0, 0, 0, 0);
    run_pixels(0, 1620, 1'b1, 100, 100);
    resetn   = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    check("t6_rst_tready", 32'(s_tready), 32'd0);
    check("t6_pre_valid", 32'(m_tvalid), 32'd1);
    check("t6_pre_data", 32'(m_tdata), 32'd1619);
    @(posedge clk);
    #1;
    resetn     = 1'b1;
    m_tready   = 1'b1;
    prev_stall = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(m_tvalid), 32'd0);
    check("t6_data", 32'(m_tdata), 32'd0);
    check("t6_flags", 32'({m_tuser, m_tlast}), 32'd0);
`ifdef CROP_WINDOW_STATUS_EN
    check("t6_err", 32'(err_sof_early), 32'd0);
`endif
    @(posedge clk);
    #1;
    k = 0;
    run_pixels(9000, 200, 1'b0, 100, 100);
    drain(100);
    check("t6_idle_drop", 32'(k), 32'd0);

    // T3 (next frame after T6): crop (150,99) clamps to (112,52)
    begin_frame(150, 99, 112, 52);
    run_pixels(0, 16000, 1'b1, 100, 100);
    drain(100);
    check("t3_beats", 32'(k), 32'd2304);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
